// File: rtl/clic_irq_arbiter.sv
// clic_irq_arbiter: picks the top-ranked pending CLIC source and offers it with kill/claim handshakes.
// Define CLIC_EDGE_TRIG_EN for edge-triggered sources with internal pending latches.
module clic_irq_arbiter #(
    parameter int NumSrc  = 64,
    parameter int IdWidth = $clog2(NumSrc)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumSrc-1:0]    src_pending_i,
    input  logic [NumSrc-1:0]    src_enable_i,
    input  logic [NumSrc*8-1:0]  src_level_i,
    input  logic [NumSrc*2-1:0]  src_priv_i,
    output logic                 irq_valid_o,
    input  logic                 irq_ready_i,
    output logic [IdWidth-1:0]   irq_id_o,
    output logic [7:0]           irq_level_o,
    output logic [1:0]           irq_priv_o,
    output logic                 kill_req_o,
    input  logic                 kill_ack_i,
    output logic                 claim_valid_o,
    output logic [IdWidth-1:0]   claim_id_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] OFFER = 2'd1;
    localparam logic [1:0] KILL  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [NumSrc-1:0]   pend, cand;
    logic                best_valid_q, best_valid_d;
    logic [IdWidth-1:0]  best_id_q, best_id_d;
    logic [7:0]          best_level_q, best_level_d;
    logic [1:0]          best_priv_q, best_priv_d;
    logic [IdWidth-1:0]  off_id_q;
    logic [7:0]          off_level_q;
    logic [1:0]          off_priv_q;
    logic                claim, load, off_live, kill;

`ifdef CLIC_EDGE_TRIG_EN
    logic [NumSrc-1:0] prev_q, edge_q, clr_vec;

    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < NumSrc; i++) clr_vec[i] = claim && (off_id_q == IdWidth'(i));
    end

    // a new rising edge in the claim cycle must survive the clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= '0;
            edge_q <= '0;
        end else begin
            prev_q <= src_pending_i;
            edge_q <= (src_pending_i & ~prev_q) | (edge_q & ~clr_vec);
        end
    end

    // hide the source being claimed so it is not re-offered from a stale latch
    assign pend = edge_q;
    assign cand = edge_q & ~clr_vec & src_enable_i;
`else
    assign pend = src_pending_i;
    assign cand = src_pending_i & src_enable_i;
`endif

    // later (higher) IDs win ties through the >= comparison
    always_comb begin
        best_valid_d = 1'b0;
        best_id_d    = '0;
        best_level_d = '0;
        best_priv_d  = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (cand[i] && (!best_valid_d ||
                {src_priv_i[2*i +: 2], src_level_i[8*i +: 8]} >= {best_priv_d, best_level_d})) begin
                best_valid_d = 1'b1;
                best_id_d    = IdWidth'(i);
                best_level_d = src_level_i[8*i +: 8];
                best_priv_d  = src_priv_i[2*i +: 2];
            end
        end
    end

    always_comb begin
        off_live = 1'b0;
        for (int i = 0; i < NumSrc; i++)
            if (off_id_q == IdWidth'(i)) off_live = pend[i] & src_enable_i[i];
    end

    assign kill = (best_valid_q && ({best_priv_q, best_level_q} > {off_priv_q, off_level_q})) || !off_live;

    always_comb begin
        state_d = state_q;
        claim   = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                load    = best_valid_q;
                state_d = best_valid_q ? OFFER : IDLE;
            end
            OFFER: begin
                claim   = irq_ready_i;
                state_d = irq_ready_i ? IDLE : (kill ? KILL : OFFER);
            end
            KILL: begin
                claim   = irq_ready_i;
                state_d = (irq_ready_i || kill_ack_i) ? IDLE : KILL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            best_valid_q <= 1'b0;
            best_id_q    <= '0;
            best_level_q <= '0;
            best_priv_q  <= '0;
            off_id_q     <= '0;
            off_level_q  <= '0;
            off_priv_q   <= '0;
        end else begin
            state_q      <= state_d;
            best_valid_q <= best_valid_d;
            best_id_q    <= best_id_d;
            best_level_q <= best_level_d;
            best_priv_q  <= best_priv_d;
            if (load) begin
                off_id_q    <= best_id_q;
                off_level_q <= best_level_q;
                off_priv_q  <= best_priv_q;
            end
        end
    end

    assign irq_valid_o   = state_q == OFFER;
    assign kill_req_o    = state_q == KILL;
    assign irq_id_o      = off_id_q;
    assign irq_level_o   = off_level_q;
    assign irq_priv_o    = off_priv_q;
    assign claim_valid_o = claim;
    assign claim_id_o    = claim ? off_id_q : '0;
endmodule

// File: tb/tb_clic_irq_arbiter.sv
// tb_clic_irq_arbiter: scenario tasks with a scoreboard of expected offers.
module tb_clic_irq_arbiter;
    typedef struct packed {
        logic [5:0] id;
        logic [7:0] lvl;
        logic [1:0] prv;
    } offer_t;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic [63:0]  pend = '0, en = '0;
    logic [511:0] lvl = '0;
    logic [127:0] prv = '0;
    logic         ready = 1'b0, kill_ack = 1'b0;
    logic         irq_valid_o, kill_req_o, claim_valid_o;
    logic [5:0]   irq_id_o, claim_id_o;
    logic [7:0]   irq_level_o;
    logic [1:0]   irq_priv_o;

    offer_t exp_q[$];
    offer_t e;
    int checks = 0, failures = 0, claim_cnt = 0;

    clic_irq_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .src_pending_i(pend), .src_enable_i(en), .src_level_i(lvl), .src_priv_i(prv),
        .irq_valid_o(irq_valid_o), .irq_ready_i(ready),
        .irq_id_o(irq_id_o), .irq_level_o(irq_level_o), .irq_priv_o(irq_priv_o),
        .kill_req_o(kill_req_o), .kill_ack_i(kill_ack),
        .claim_valid_o(claim_valid_o), .claim_id_o(claim_id_o)
    );

    always #5 clk_i = ~clk_i;
    always @(negedge clk_i) if (claim_valid_o) claim_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        pend = '0; en = '0; lvl = '0; prv = '0;
        ready = 1'b0; kill_ack = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        tick();
    endtask

    task automatic set_src(input int id, input logic [7:0] l, input logic [1:0] p);
        lvl[8*id +: 8] = l;
        prv[2*id +: 2] = p;
        en[id] = 1'b1;
        pend[id] = 1'b1;
    endtask

    task automatic wait_for(input bit want_kill, input int budget, output bit ok);
        ok = 1'b0;
        repeat (budget) begin
            if (want_kill ? kill_req_o : irq_valid_o) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
        ok = want_kill ? kill_req_o : irq_valid_o;
    endtask

    task automatic pop_exp();
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty");
            e = '0;
        end else e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        set_src(1, 8'h11, 2'd3);
        ready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({irq_valid_o, kill_req_o, claim_valid_o, irq_id_o, irq_level_o, irq_priv_o, claim_id_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {irq_valid_o, kill_req_o, claim_valid_o, irq_id_o, irq_level_o, irq_priv_o, claim_id_o});
        end
        do_reset();
    endtask

    task automatic test_single();
        int lat;
        bit early;
`ifdef CLIC_EDGE_TRIG_EN
        lat = 3;
`else
        lat = 2;
`endif
        do_reset();
        set_src(5, 8'h40, 2'd3);
        exp_q.push_back(offer_t'({6'd5, 8'h40, 2'd3}));
        early = 1'b0;
        for (int c = 1; c < lat; c++) begin
            tick();
            early |= irq_valid_o;
        end
        checks++;
        if (early !== 1'b0) begin failures++; $display("FAIL single_early got=1 exp=0"); end
        tick();
        checks++;
        if (irq_valid_o !== 1'b1) begin failures++; $display("FAIL single_latency got=%b exp=1", irq_valid_o); end
        pop_exp();
        checks++;
        if ({irq_id_o, irq_level_o, irq_priv_o} !== e) begin
            failures++;
            $display("FAIL single_offer got=%h exp=%h", {irq_id_o, irq_level_o, irq_priv_o}, e);
        end
        tick();
        tick();
        ready = 1'b1;
        pend[5] = 1'b0;
        #1;
        checks++;
        if ({claim_valid_o, claim_id_o} !== {1'b1, 6'd5}) begin
            failures++;
            $display("FAIL single_claim got=%b/%0d exp=1/5", claim_valid_o, claim_id_o);
        end
        tick();
        ready = 1'b0;
        checks++;
        if (irq_valid_o !== 1'b0) begin failures++; $display("FAIL single_drop got=%b exp=0", irq_valid_o); end
    endtask

    task automatic test_ranking();
        bit ok;
        do_reset();
        set_src(3, 8'h10, 2'd3);
        set_src(9, 8'hF0, 2'd1);
        set_src(12, 8'h10, 2'd3);
        exp_q.push_back(offer_t'({6'd12, 8'h10, 2'd3}));
        exp_q.push_back(offer_t'({6'd3, 8'h10, 2'd3}));
        exp_q.push_back(offer_t'({6'd9, 8'hF0, 2'd1}));
        for (int k = 0; k < 3; k++) begin
            wait_for(1'b0, 12, ok);
            pop_exp();
            checks++;
            if (!ok || {irq_id_o, irq_level_o, irq_priv_o} !== e) begin
                failures++;
                $display("FAIL rank_offer%0d ok=%b got=%h exp=%h", k, ok, {irq_id_o, irq_level_o, irq_priv_o}, e);
            end
            ready = 1'b1;
            pend[e.id] = 1'b0;
            #1;
            checks++;
            if ({claim_valid_o, claim_id_o} !== {1'b1, e.id}) begin
                failures++;
                $display("FAIL rank_claim%0d got=%b/%0d exp=1/%0d", k, claim_valid_o, claim_id_o, e.id);
            end
            tick();
            ready = 1'b0;
        end
    endtask

    task automatic test_preempt();
        bit ok;
        int c0;
        do_reset();
        set_src(2, 8'h20, 2'd3);
        exp_q.push_back(offer_t'({6'd2, 8'h20, 2'd3}));
        wait_for(1'b0, 12, ok);
        pop_exp();
        checks++;
        if (!ok || {irq_id_o, irq_level_o, irq_priv_o} !== e) begin
            failures++;
            $display("FAIL preempt_first ok=%b got=%h exp=%h", ok, {irq_id_o, irq_level_o, irq_priv_o}, e);
        end
        c0 = claim_cnt;
        set_src(7, 8'h80, 2'd3);
        exp_q.push_back(offer_t'({6'd7, 8'h80, 2'd3}));
        wait_for(1'b1, 12, ok);
        checks++;
        if (!ok || {kill_req_o, irq_valid_o} !== 2'b10) begin
            failures++;
            $display("FAIL preempt_kill ok=%b got=%b%b exp=10", ok, kill_req_o, irq_valid_o);
        end
        repeat (3) tick();
        kill_ack = 1'b1;
        tick();
        kill_ack = 1'b0;
        wait_for(1'b0, 12, ok);
        pop_exp();
        checks++;
        if (!ok || {irq_id_o, irq_level_o, irq_priv_o} !== e) begin
            failures++;
            $display("FAIL preempt_reoffer ok=%b got=%h exp=%h", ok, {irq_id_o, irq_level_o, irq_priv_o}, e);
        end
        checks++;
        if (claim_cnt !== c0) begin failures++; $display("FAIL preempt_noclaim got=%0d exp=%0d", claim_cnt, c0); end
    endtask

    task automatic test_kill_ready();
        bit ok;
        do_reset();
        set_src(2, 8'h20, 2'd3);
        wait_for(1'b0, 12, ok);
        set_src(7, 8'h80, 2'd3);
        wait_for(1'b1, 12, ok);
        ready = 1'b1;
        kill_ack = 1'b1;
        #1;
        checks++;
        if (!ok || {claim_valid_o, claim_id_o} !== {1'b1, 6'd2}) begin
            failures++;
            $display("FAIL killready_claim ok=%b got=%b/%0d exp=1/2", ok, claim_valid_o, claim_id_o);
        end
        tick();
        ready = 1'b0;
        kill_ack = 1'b0;
        checks++;
        if (kill_req_o !== 1'b0) begin failures++; $display("FAIL killready_drop got=%b exp=0", kill_req_o); end
    endtask

    task automatic test_disable();
        bit ok, seen;
        do_reset();
        set_src(6, 8'h33, 2'd1);
        exp_q.push_back(offer_t'({6'd6, 8'h33, 2'd1}));
        wait_for(1'b0, 12, ok);
        pop_exp();
        checks++;
        if (!ok || {irq_id_o, irq_level_o, irq_priv_o} !== e) begin
            failures++;
            $display("FAIL disable_offer ok=%b got=%h exp=%h", ok, {irq_id_o, irq_level_o, irq_priv_o}, e);
        end
        en[6] = 1'b0;
        wait_for(1'b1, 12, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL disable_kill got=0 exp=1"); end
        kill_ack = 1'b1;
        tick();
        kill_ack = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            tick();
            seen |= irq_valid_o | kill_req_o;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL disable_quiet got=1 exp=0"); end
    endtask

    task automatic test_idle_ignore();
        bit seen;
        do_reset();
        lvl[8*3 +: 8] = 8'h77;
        pend[3] = 1'b1;
        ready = 1'b1;
        kill_ack = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            tick();
            seen |= irq_valid_o | kill_req_o | claim_valid_o;
        end
        ready = 1'b0;
        kill_ack = 1'b0;
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL idle_nocand got=1 exp=0"); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        set_src(8, 8'h5A, 2'd3);
        wait_for(1'b0, 12, ok);
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (!ok || {irq_valid_o, kill_req_o, irq_id_o, irq_level_o, irq_priv_o} !== '0) begin
            failures++;
            $display("FAIL reset_mid_offer ok=%b got=%h exp=0", ok, {irq_valid_o, kill_req_o, irq_id_o, irq_level_o, irq_priv_o});
        end
        do_reset();
        set_src(8, 8'h5A, 2'd3);
        wait_for(1'b0, 12, ok);
        en[8] = 1'b0;
        wait_for(1'b1, 12, ok);
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (!ok || {irq_valid_o, kill_req_o, irq_id_o, irq_level_o, irq_priv_o} !== '0) begin
            failures++;
            $display("FAIL reset_mid_kill ok=%b got=%h exp=0", ok, {irq_valid_o, kill_req_o, irq_id_o, irq_level_o, irq_priv_o});
        end
        do_reset();
    endtask

`ifdef CLIC_EDGE_TRIG_EN
    task automatic test_edge();
        bit ok, bad;
        do_reset();
        set_src(4, 8'h50, 2'd3);
        exp_q.push_back(offer_t'({6'd4, 8'h50, 2'd3}));
        tick();
        pend[4] = 1'b0;
        wait_for(1'b0, 12, ok);
        pop_exp();
        checks++;
        if (!ok || {irq_id_o, irq_level_o, irq_priv_o} !== e) begin
            failures++;
            $display("FAIL edge_offer ok=%b got=%h exp=%h", ok, {irq_id_o, irq_level_o, irq_priv_o}, e);
        end
        bad = 1'b0;
        repeat (4) begin
            tick();
            bad |= !irq_valid_o | kill_req_o;
        end
        checks++;
        if (bad !== 1'b0) begin failures++; $display("FAIL edge_hold got=1 exp=0"); end
        ready = 1'b1;
        #1;
        checks++;
        if ({claim_valid_o, claim_id_o} !== {1'b1, 6'd4}) begin
            failures++;
            $display("FAIL edge_claim got=%b/%0d exp=1/4", claim_valid_o, claim_id_o);
        end
        tick();
        ready = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            tick();
            bad |= irq_valid_o;
        end
        checks++;
        if (bad !== 1'b0) begin failures++; $display("FAIL edge_noreoffer got=1 exp=0"); end
        pend[4] = 1'b1;
        tick();
        pend[4] = 1'b0;
        wait_for(1'b0, 12, ok);
        ready = 1'b1;
        pend[4] = 1'b1;
        exp_q.push_back(offer_t'({6'd4, 8'h50, 2'd3}));
        #1;
        checks++;
        if (!ok || {claim_valid_o, claim_id_o} !== {1'b1, 6'd4}) begin
            failures++;
            $display("FAIL edge_claim2 ok=%b got=%b/%0d exp=1/4", ok, claim_valid_o, claim_id_o);
        end
        tick();
        ready = 1'b0;
        pend[4] = 1'b0;
        wait_for(1'b0, 12, ok);
        pop_exp();
        checks++;
        if (!ok || {irq_id_o, irq_level_o, irq_priv_o} !== e) begin
            failures++;
            $display("FAIL edge_setwins ok=%b got=%h exp=%h", ok, {irq_id_o, irq_level_o, irq_priv_o}, e);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_ranking();
        test_preempt();
        test_kill_ready();
        test_disable();
        test_idle_ignore();
        test_reset_mid();
`ifdef CLIC_EDGE_TRIG_EN
        test_edge();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clic_irq_arbiter.md
Name: clic_irq_arbiter

Overview:
- Selects the highest-priority pending, enabled interrupt among NumSrc CLIC sources and offers it to the core-side CLIC controller.
- Offer interface: valid/ready plus id, level and privilege.
- Withdraws a stale or outranked offer through a kill request/acknowledge handshake.
- Signals each claimed interrupt back to the CLIC register file so it can clear pending state.

Parameters:
- NumSrc, 64: number of interrupt sources; minimum 2.
- IdWidth, $clog2(NumSrc): width of interrupt IDs.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- src_pending_i  in  NumSrc  per-source pending (level) or raw request (edge mode)
- src_enable_i  in  NumSrc  per-source enable
- src_level_i  in  NumSrc*8  per-source interrupt level; source i at [8i+7:8i]
- src_priv_i  in  NumSrc*2  per-source privilege (riscv priv encoding: M=3, S=1, U=0)
- irq_valid_o  out  1  offer valid
- irq_ready_i  in  1  controller acknowledged (took) the offer
- irq_id_o  out  IdWidth  offered ID
- irq_level_o  out  8  offered level
- irq_priv_o  out  2  offered privilege
- kill_req_o  out  1  request withdrawal of the current offer
- kill_ack_i  in  1  withdrawal acknowledged
- claim_valid_o  out  1  one-cycle pulse: offered interrupt was taken
- claim_id_o  out  IdWidth  ID taken; valid with claim_valid_o

Behaviour:
- Candidate: src_pending & src_enable. Rank key is {priv, level}, compared unsigned.
- Tie on the rank key: the higher ID wins.
- Selection stage:
  - Combinational max over all candidates.
  - Registered each cycle into best_valid_q, best_id_q, best_level_q, best_priv_q.
  - This gives one cycle of latency from an input change to best_q.
- Offer registers: off_id_q, off_level_q, off_priv_q drive irq_id_o, irq_level_o and irq_priv_o. They are stable whenever irq_valid_o=1.
- FSM states: IDLE, OFFER, KILL.
- IDLE:
  - irq_valid_o=0, kill_req_o=0.
  - If best_valid_q: load the offer registers from best_q and go to OFFER.
  - irq_valid_o rises the cycle after entry, so minimum latency from src_pending_i rising to irq_valid_o is 2 cycles.
- OFFER (irq_valid_o=1):
  - Priority 1: irq_ready_i=1 → claim_valid_o=1 in the same cycle (combinational), claim_id_o=off_id_q, go to IDLE.
  - Priority 2, otherwise: kill if either condition holds, then go to KILL:
    - best_valid_q with a key strictly greater than the offer key.
    - The offered source is no longer pending or no longer enabled (sampled directly from the inputs).
  - Otherwise stay in OFFER.
- KILL (irq_valid_o=0, kill_req_o=1):
  - If irq_ready_i=1 (the controller had already taken the offer): claim pulse with off_id_q, drop kill_req, go to IDLE. kill_ack_i in the same cycle is ignored.
  - Else if kill_ack_i=1: go to IDLE with no claim.
  - Else hold.
- Any kill_ack_i outside KILL, and any irq_ready_i in IDLE, is ignored.
- After a return to IDLE, re-offer uses the current best_q. The new offer is never earlier than the cycle after IDLE.
- Reset, including mid-offer or mid-kill:
  - FSM to IDLE.
  - All outputs 0: irq_valid_o, kill_req_o, claim_valid_o, irq_id_o, irq_level_o, irq_priv_o, claim_id_o.
  - best_valid_q=0; edge latches cleared.
- No candidates: best_valid_q=0 and the FSM stays in IDLE.

Optional Feature:
- Macro: CLIC_EDGE_TRIG_EN.
- With the macro defined:
  - Each source is edge-triggered.
  - An internal pending flop sets on a 0→1 transition of src_pending_i; that transition is detected with a registered previous value.
  - The flop clears in the cycle claim_valid_o=1 for that ID.
  - Set and clear in the same cycle: set wins.
  - The candidate and the "offered source no longer pending" test use the internal flop instead of src_pending_i.
- Without the macro: level-sensitive, src_pending_i used directly, and no edge flops are synthesized.

Test Plan:
- Single source: src 5, level 0x40, priv M, enabled; pending rises at cycle 0 → irq_valid_o=1 at cycle 2 with id=5, level=0x40, priv=3. irq_ready_i at cycle 4 → claim_valid_o=1 with claim_id_o=5 at cycle 4, irq_valid_o=0 at cycle 5.
- Ranking: src 3 {M,0x10}, src 9 {S,0xF0} and src 12 {M,0x10} pending together → offer id=12. After its claim and deassert, the next offer is id=3, then id=9.
- Preemption: offer id=2 {M,0x20} outstanding; src 7 {M,0x80} becomes pending → kill_req_o=1 and irq_valid_o=0. kill_ack_i 3 cycles later → IDLE, then offer id=7. No claim pulse for 2.
- Ready during kill: in KILL, irq_ready_i=1 and kill_ack_i=1 in the same cycle → claim_valid_o=1 with claim_id_o=old ID, kill_req_o=0 next cycle.
- Disable mid-offer: src_enable_i[id] cleared while in OFFER → KILL. kill_ack_i → IDLE. With no other candidates, irq_valid_o stays 0.
- Edge mode (CLIC_EDGE_TRIG_EN): a 1-cycle pulse on src 4 → offer id=4, held while the input is low. After the claim, internal pending is 0 and there is no re-offer. A second pulse arriving in the claim cycle is re-offered.
